// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   DEF_DIVIDEND_W : default dividend / quotient width
//   DEF_DIVISOR_W  : default divisor / remainder width
//   CNT_W          : iteration counter width for the default dividend width
//   state_t        : controller states (IDLE, RUN)
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int CNT_W          = $clog2(DEF_DIVIDEND_W);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   prem_in  : partial remainder entering the step (W+1 bits, always < divisor)
//   bit_in   : next dividend bit, MSB first
//   divisor  : unsigned divisor (W bits)
//   prem_out : partial remainder after the step
//   q_bit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int W = DEF_DIVISOR_W
) (
  input  logic [W:0]   prem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   prem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The shifted value is always below 2*divisor, so one extra bit above the
  // partial remainder is enough to act as the sign of the trial difference.
  always_comb begin
    shifted  = {prem_in, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[W+1];
    prem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/seq_divider_16.sv
// ---------------------------------------------------------------------------
// seq_divider_16
// Iterative restoring divider: DIVIDEND_W-bit unsigned dividend divided by a
// DIVISOR_W-bit unsigned divisor, one quotient bit per clock.
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   start       : request, sampled only while idle
//   dividend    : dividend, captured on the accepted start edge
//   divisor     : divisor, captured on the accepted start edge
//   busy        : high from the accepted start until the result edge
//   done        : one-cycle pulse, results valid from this cycle onward
//   quotient    : result, held until the next result edge
//   remainder   : result, held until the next result edge
//   div_by_zero : status of the last completed operation
// ---------------------------------------------------------------------------
module seq_divider_16
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int            CW   = $clog2(DIVIDEND_W);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

  state_t                 state, next_state;
  logic [DIVIDEND_W-1:0]  dvd_sr;
  logic [DIVIDEND_W-1:0]  q_sr;
  logic [DIVISOR_W-1:0]   dvs;
  logic [DIVISOR_W:0]     prem;
  logic [DIVISOR_W:0]     prem_next;
  logic [CW-1:0]          count;
  logic                   zero_flag;
  logic                   q_bit;
  logic                   load;
  logic                   last_step;

  div_step #(
    .W(DIVISOR_W)
  ) u_step (
    .prem_in (prem),
    .bit_in  (dvd_sr[DIVIDEND_W-1]),
    .divisor (dvs),
    .prem_out(prem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)     next_state = RUN;
      RUN:     if (last_step) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A zero divisor finishes on the first RUN edge without iterating.
  always_comb begin
    busy      = (state == RUN);
    load      = (state == IDLE) && start;
    last_step = (state == RUN) && (zero_flag || (count == LAST));
  end

  // Datapath: operand capture, one restoring step per RUN edge, and the
  // result registers that only change on a result edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sr      <= '0;
      q_sr        <= '0;
      dvs         <= '0;
      prem        <= '0;
      count       <= '0;
      zero_flag   <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        dvd_sr    <= dividend;
        dvs       <= divisor;
        q_sr      <= '0;
        prem      <= '0;
        count     <= '0;
        zero_flag <= (divisor == '0);
      end else if (state == RUN) begin
        if (zero_flag) begin
          quotient    <= '1;
          remainder   <= '0;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else begin
          prem   <= prem_next;
          dvd_sr <= dvd_sr << 1;
          q_sr   <= {q_sr[DIVIDEND_W-2:0], q_bit};
          count  <= count + 1'b1;
          if (last_step) begin
            quotient    <= {q_sr[DIVIDEND_W-2:0], q_bit};
            remainder   <= prem_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_16.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_16
// Directed and random bench for seq_divider_16 with a scoreboard queue of
// expected results.
// ---------------------------------------------------------------------------
module tb_seq_divider_16;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   lat;
  int   busy_cnt;
  int   done_cnt;

  seq_divider_16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, sampled on the falling edge, with running busy/done counts.
  task automatic tick();
    @(negedge clk);
    lat++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic driveStart(input logic [15:0] n, input logic [7:0] d);
    exp_t e;
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    e.q  = (d == 8'd0) ? 16'hFFFF : n / 16'(d);
    e.r  = (d == 8'd0) ? 8'd0 : 8'(n % 16'(d));
    e.dz = (d == 8'd0);
    sb.push_back(e);
  endtask

  // Called on the falling edge right after the accepting rising edge.
  task automatic releaseStart();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] n, input logic [7:0] d);
    @(negedge clk);
    driveStart(n, d);
    @(negedge clk);
    releaseStart();
  endtask

  task automatic waitDone(input int limit);
    while (!done && lat < limit) tick();
  endtask

  task automatic checkOutput(input string tag, input int exp_lat, input int exp_busy);
    exp_t e;
    check({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"}, 32'(quotient), 32'(e.q));
      check({tag, "_r"}, 32'(remainder), 32'(e.r));
      check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;
    checks   = 0;
    errors   = 0;
    lat      = 0;
    busy_cnt = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'd72, 8'd8);
    waitDone(40);
    checkOutput("72_8", 16, 16);
    tick();
    check("72_8_pulse", 32'(done), 32'd0);

    applyStimulus(16'd1000, 8'd7);
    waitDone(40);
    checkOutput("1000_7", 16, 16);

    applyStimulus(16'd65535, 8'd255);
    waitDone(40);
    checkOutput("65535_255", 16, 16);

    applyStimulus(16'd5, 8'd200);
    waitDone(40);
    checkOutput("5_200", 16, 16);

    applyStimulus(16'd300, 8'd0);
    waitDone(40);
    checkOutput("300_0", 1, 1);

    // A second start while busy must be ignored.
    applyStimulus(16'd100, 8'd3);
    tick();
    tick();
    tick();
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 8'd5;
    tick();
    start    = 1'b0;
    waitDone(40);
    checkOutput("busy_start", 16, 16);
    repeat (20) tick();
    check("busy_start_single_done", 32'(done_cnt), 32'd1);

    // Reset in the middle of an operation.
    applyStimulus(16'd5000, 8'd13);
    while (lat < 8) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    check("midrst_dz", 32'(div_by_zero), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (20) tick();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(16'd81, 8'd9);
    waitDone(40);
    checkOutput("81_9", 16, 16);

    // Back-to-back: new start held in the done cycle of the previous one.
    applyStimulus(16'd1000, 8'd7);
    waitDone(40);
    checkOutput("b2b_first", 16, 16);
    driveStart(16'd72, 8'd8);
    @(negedge clk);
    releaseStart();
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_hold_q", 32'(quotient), 32'd142);
    check("b2b_hold_r", 32'(remainder), 32'd6);
    waitDone(40);
    checkOutput("b2b_second", 16, 16);

    for (int i = 0; i < 1000; i++) begin
      rn = 16'($urandom_range(0, 65535));
      rd = 8'($urandom_range(1, 255));
      applyStimulus(rn, rd);
      waitDone(40);
      checkOutput("rand", 16, 16);
      check("rand_rel",
            32'((32'(quotient) * 32'(rd) + 32'(remainder) == 32'(rn)) && (remainder < rd)),
            32'd1);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
